// File: rtl/uart_cmd_decoder.sv
// UART command decoder: maps received command characters onto one-cycle
// control pulses, with optional digit-prefixed repeat bursts and a TX ack byte.
module uart_cmd_decoder #(
   parameter int PULSE_GAP     = 16,
   parameter int DIGIT_TIMEOUT = 100_000_000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] rx_data,
   input  logic       rx_done,
   input  logic [1:0] sw_mode,
   input  logic       tx_busy,
   output logic       tx_start,
   output logic [7:0] tx_data,
   output logic       cmd_run,
   output logic       cmd_clear,
   output logic       cmd_sec,
   output logic       cmd_min,
   output logic       cmd_hour,
   output logic       cmd_ultra,
   output logic       cmd_dht,
   output logic       cmd_overrun
);

   localparam int GW = (PULSE_GAP > 1) ? $clog2(PULSE_GAP) : 1;
   localparam int TW = $clog2(DIGIT_TIMEOUT);

   typedef enum logic [1:0] {IDLE, PULSE, GAP, ACK} state_t;

   state_t          state;
   logic [3:0]      rep_n;
   logic [3:0]      remain;
   logic            digit_pend;
   logic [TW-1:0]   tmo_cnt;
   logic [GW-1:0]   gap_cnt;
   logic [6:0]      cmd_sel;
   logic [6:0]      cmd_q;
   logic [7:0]      cmd_chr;

   logic [7:0]      up_chr;
   logic [6:0]      dec_hot;
   logic [1:0]      dec_mode;
   logic            is_letter;
   logic            is_digit;

   // Fold lowercase onto uppercase, then map letter -> one-hot command and required mode.
   always_comb begin
      up_chr    = rx_data;
      dec_hot   = 7'b0;
      dec_mode  = 2'b00;
      is_letter = 1'b1;
      if (rx_data >= 8'h61 && rx_data <= 8'h7A)
         up_chr = rx_data - 8'h20;
      case (up_chr)
         8'h52:   begin dec_hot = 7'b0000001; dec_mode = 2'b00; end
         8'h43:   begin dec_hot = 7'b0000010; dec_mode = 2'b00; end
         8'h53:   begin dec_hot = 7'b0000100; dec_mode = 2'b01; end
         8'h4D:   begin dec_hot = 7'b0001000; dec_mode = 2'b01; end
         8'h48:   begin dec_hot = 7'b0010000; dec_mode = 2'b01; end
         8'h55:   begin dec_hot = 7'b0100000; dec_mode = 2'b10; end
         8'h44:   begin dec_hot = 7'b1000000; dec_mode = 2'b11; end
         default: is_letter = 1'b0;
      endcase
      is_digit = (rx_data >= 8'h31) && (rx_data <= 8'h39);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         rep_n      <= 4'd1;
         remain     <= 4'd0;
         digit_pend <= 1'b0;
         tmo_cnt    <= '0;
         gap_cnt    <= '0;
         cmd_sel    <= 7'b0;
         cmd_q      <= 7'b0;
         cmd_chr    <= 8'h00;
         tx_data    <= 8'h00;
      end else begin
         cmd_q <= 7'b0;
         unique case (state)
            IDLE: begin
               if (rx_done) begin
                  tmo_cnt <= '0;
                  if (is_digit) begin
                     rep_n      <= rx_data[3:0];
                     digit_pend <= 1'b1;
                  end else if (is_letter && dec_mode == sw_mode) begin
                     cmd_sel <= dec_hot;
                     cmd_q   <= dec_hot;
                     cmd_chr <= up_chr;
                     remain  <= rep_n;
                     state   <= PULSE;
                  end else begin
                     tx_data    <= is_letter ? 8'h21 : 8'h3F;
                     rep_n      <= 4'd1;
                     digit_pend <= 1'b0;
                     state      <= ACK;
                  end
               end else if (digit_pend) begin
                  if (tmo_cnt == TW'(DIGIT_TIMEOUT - 1)) begin
                     rep_n      <= 4'd1;
                     digit_pend <= 1'b0;
                     tmo_cnt    <= '0;
                  end else begin
                     tmo_cnt <= tmo_cnt + 1'b1;
                  end
               end
            end
            PULSE: begin
               gap_cnt <= '0;
               if (remain > 4'd1) begin
                  remain <= remain - 4'd1;
                  state  <= GAP;
               end else begin
                  remain  <= 4'd0;
                  tx_data <= cmd_chr;
                  state   <= ACK;
               end
            end
            GAP: begin
               if (gap_cnt == GW'(PULSE_GAP - 1)) begin
                  cmd_q <= cmd_sel;
                  state <= PULSE;
               end else begin
                  gap_cnt <= gap_cnt + 1'b1;
               end
            end
            ACK: begin
               if (!tx_busy) begin
                  rep_n      <= 4'd1;
                  digit_pend <= 1'b0;
                  state      <= IDLE;
               end
            end
         endcase
      end
   end

   // tx_start reacts to tx_busy in the same cycle so the ack goes out on the first free cycle.
   assign tx_start    = !rst && (state == ACK) && !tx_busy;
   assign cmd_overrun = !rst && rx_done && (state != IDLE);

   assign cmd_run   = cmd_q[0];
   assign cmd_clear = cmd_q[1];
   assign cmd_sec   = cmd_q[2];
   assign cmd_min   = cmd_q[3];
   assign cmd_hour  = cmd_q[4];
   assign cmd_ultra = cmd_q[5];
   assign cmd_dht   = cmd_q[6];

endmodule
